// File: rtl/sign_ext_pkg.sv
// Shared types and default lengths for the registered immediate extender.
// Optional left-shift-by-one feature is enabled with SIGN_EXT_SHL1_EN.
package sign_ext_pkg;

    typedef enum logic [1:0] {
        LEN_A    = 2'd0,
        LEN_B    = 2'd1,
        LEN_C    = 2'd2,
        LEN_FULL = 2'd3
    } ext_len_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int DEF_LEN0 = 5;
    localparam int DEF_LEN1 = 8;
    localparam int DEF_LEN2 = 11;

    // Maps a length select onto the number of live field bits.
    function automatic int len_width(input ext_len_t len, input int l0, input int l1,
                                     input int l2, input int full_w);
        int w;
        case (len)
            LEN_A:    w = l0;
            LEN_B:    w = l1;
            LEN_C:    w = l2;
            LEN_FULL: w = full_w;
            default:  w = full_w;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sign_ext_pipe_if.sv
// Stream interface between decode (master) and the extender pipe (slave).
// in_shl1 only exists when SIGN_EXT_SHL1_EN is defined.
interface sign_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_field;
    logic [1:0]       in_len;
    logic             in_zext;
`ifdef SIGN_EXT_SHL1_EN
    logic             in_shl1;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_field, in_len, in_zext,
`ifdef SIGN_EXT_SHL1_EN
        output in_shl1,
`endif
        input  in_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  in_valid, in_field, in_len, in_zext,
`ifdef SIGN_EXT_SHL1_EN
        input  in_shl1,
`endif
        output in_ready,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/sign_ext_core.sv
// Combinational field select and sign/zero extension of a raw immediate.
// With SIGN_EXT_SHL1_EN the extended value may additionally be shifted left by one.
module sign_ext_core
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int LEN0  = DEF_LEN0,
    parameter int LEN1  = DEF_LEN1,
    parameter int LEN2  = DEF_LEN2
) (
    input  logic [IN_W-1:0]  field,
    input  logic [1:0]       len,
    input  logic             zext,
`ifdef SIGN_EXT_SHL1_EN
    input  logic             shl1,
`endif
    output logic [OUT_W-1:0] ext
);
    localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [OUT_W-1:0] field_wide_s;
    logic [OUT_W-1:0] ext_s;
    logic [IDX_W-1:0] msb_idx_s;
    logic             fill_s;
    int               len_w_s;

    // Keep the low L bits and replicate the fill bit above them.
    always_comb begin
        field_wide_s             = '0;
        field_wide_s[IN_W-1:0]   = field;
        len_w_s                  = len_width(ext_len_t'(len), LEN0, LEN1, LEN2, IN_W);
        msb_idx_s                = IDX_W'(len_w_s - 1);
        fill_s                   = zext ? 1'b0 : field_wide_s[msb_idx_s];
        ext_s                    = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (i < len_w_s) begin
                ext_s[i] = field_wide_s[i];
            end else begin
                ext_s[i] = fill_s;
            end
        end
    end

`ifdef SIGN_EXT_SHL1_EN
    // Branch displacements are halfword-scaled, so shift after extension.
    always_comb begin
        if (shl1) begin
            ext = {ext_s[OUT_W-2:0], 1'b0};
        end else begin
            ext = ext_s;
        end
    end
`else
    // No shift option in this build.
    always_comb begin
        ext = ext_s;
    end
`endif

endmodule

// File: rtl/sign_ext_pipe.sv
// Registered immediate extender with a 2-entry skid buffer on a valid/ready stream.
// Define SIGN_EXT_SHL1_EN to add the in_shl1 post-extension left shift.
module sign_ext_pipe
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int LEN0  = DEF_LEN0,
    parameter int LEN1  = DEF_LEN1,
    parameter int LEN2  = DEF_LEN2
) (
    input  logic            clk,
    input  logic            rst,
    sign_ext_pipe_if.slave  bus
);
    skid_state_t      state_r;
    logic             out_valid_r;
    logic             skid_valid_r;
    logic [OUT_W-1:0] out_data_r;
    logic [OUT_W-1:0] skid_data_r;
    logic [OUT_W-1:0] ext_s;
    logic             in_ready_s;
    logic             in_fire_s;
    logic             out_fire_s;

    sign_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .LEN0  (LEN0),
        .LEN1  (LEN1),
        .LEN2  (LEN2)
    ) u_core (
        .field (bus.in_field),
        .len   (bus.in_len),
        .zext  (bus.in_zext),
`ifdef SIGN_EXT_SHL1_EN
        .shl1  (bus.in_shl1),
`endif
        .ext   (ext_s)
    );

    // Ready comes only from stored state so out_ready never reaches in_ready.
    always_comb begin
        in_ready_s = ~skid_valid_r & ~rst;
        in_fire_s  = bus.in_valid & in_ready_s;
        out_fire_s = out_valid_r & bus.out_ready;
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    // Skid-buffer state machine; extension result is only sampled on in_fire_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= EMPTY;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            out_data_r   <= '0;
            skid_data_r  <= '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        out_data_r  <= ext_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ONE;
                    end else begin
                        state_r     <= EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        out_data_r   <= ext_s;
                    end else if (in_fire_s) begin
                        skid_data_r  <= ext_s;
                        skid_valid_r <= 1'b1;
                        state_r      <= FULL;
                    end else if (out_fire_s) begin
                        out_valid_r  <= 1'b0;
                        state_r      <= EMPTY;
                    end else begin
                        state_r      <= ONE;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        out_data_r   <= skid_data_r;
                        skid_valid_r <= 1'b0;
                        state_r      <= ONE;
                    end else begin
                        state_r      <= FULL;
                    end
                end
                default: begin
                    state_r      <= EMPTY;
                    out_valid_r  <= 1'b0;
                    skid_valid_r <= 1'b0;
                    out_data_r   <= '0;
                    skid_data_r  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_ext_pipe.sv
// Randomised bench for sign_ext_pipe against an arithmetic reference model and scoreboard.
// Covers the shift option too when built with SIGN_EXT_SHL1_EN.
module tb_sign_ext_pipe;
    localparam int IN_W  = 16;
    localparam int OUT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sign_ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    sign_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    longint unsigned exp_q[$];
    bit chk_rdy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: value arithmetic on the field, not bit surgery.
    function automatic longint unsigned ref_ext(input longint unsigned field, input int len,
                                                input bit zext, input bit shl1);
        int L;
        longint unsigned v;
        L = (len == 0) ? 5 : (len == 1) ? 8 : (len == 2) ? 11 : IN_W;
        v = field % (64'd1 << L);
        if (!zext && v >= (64'd1 << (L - 1)))
            v = v + (64'd1 << OUT_W) - (64'd1 << L);
        if (shl1)
            v = (v * 2) % (64'd1 << OUT_W);
        return v;
    endfunction

    task automatic drive(input bit v, input logic [15:0] f, input int len, input bit z, input bit s);
        bus.in_valid = v;
        bus.in_field = f;
        bus.in_len   = 2'(len);
        bus.in_zext  = z;
`ifdef SIGN_EXT_SHL1_EN
        bus.in_shl1  = s;
`endif
    endtask

    function automatic bit cur_shl1();
`ifdef SIGN_EXT_SHL1_EN
        return bus.in_shl1;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: sample at negedge, score outputs, record accepted inputs.
    task automatic cycle();
        @(negedge clk);
        if (chk_rdy) check_eq("stream_rdy", {31'd0, bus.in_ready}, 32'd1);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check_eq("spurious", 32'd1, 32'd0);
            else check_eq("sb", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        if (bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_ext(bus.in_field, int'(bus.in_len), bus.in_zext, cur_shl1()));
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [15:0] f; int len; bit z; bit s; logic [15:0] e; } dir_t;
    dir_t dir[$];
    logic [15:0] held;

    initial begin
        drive(1'b0, 16'h0, 0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        #2;
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_rdy", {31'd0, bus.in_ready}, 32'd1);

        dir.push_back('{16'h0010, 0, 1'b1, 1'b0, 16'h0010});
        dir.push_back('{16'h0010, 0, 1'b0, 1'b0, 16'hFFF0});
        dir.push_back('{16'hA582, 1, 1'b0, 1'b0, 16'hFF82});
        dir.push_back('{16'hF3FF, 2, 1'b0, 1'b0, 16'h03FF});
        dir.push_back('{16'h8001, 3, 1'b0, 1'b0, 16'h8001});
        dir.push_back('{16'h0082, 1, 1'b1, 1'b0, 16'h0082});
`ifdef SIGN_EXT_SHL1_EN
        dir.push_back('{16'h00FE, 1, 1'b0, 1'b1, 16'hFFFC});
        dir.push_back('{16'h00FE, 1, 1'b0, 1'b0, 16'hFFFE});
`endif
        bus.out_ready = 1'b1;
        foreach (dir[k]) begin
            drive(1'b1, dir[k].f, dir[k].len, dir[k].z, dir[k].s);
            cycle();
            drive(1'b0, 16'h0, 0, 1'b0, 1'b0);
            check_eq("dir_valid", {31'd0, bus.out_valid}, 32'd1);
            check_eq($sformatf("dir%0d", k), 32'(bus.out_data), 32'(dir[k].e));
            cycle();
        end

        // Backpressure: three beats against a stalled consumer.
        bus.out_ready = 1'b0;
        for (int b = 1; b <= 3; b++) begin
            drive(1'b1, 16'(b), 3, 1'b1, 1'b0);
            if (b < 3) cycle();
        end
        check_eq("bp_rdy_low", {31'd0, bus.in_ready}, 32'd0);
        held = bus.out_data;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check_eq("bp_stable_v", {31'd0, bus.out_valid}, 32'd1);
            check_eq("bp_stable_d", 32'(bus.out_data), 32'(held));
        end
        check_eq("bp_head", 32'(bus.out_data), 32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (exp_q.size() == 0) drive(1'b0, 16'h0, 0, 1'b0, 1'b0);
        end
        drive(1'b0, 16'h0, 0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) cycle();
        check_eq("bp_drained", 32'(exp_q.size()), 32'd0);

        // Streaming: full throughput, ready must never drop.
        chk_rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            cycle();
        end
        chk_rdy = 1'b0;

        // Random valid/ready traffic.
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom));
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
        end
        drive(1'b0, 16'h0, 0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        check_eq("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset with the pipe full: everything in flight is discarded.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1234, 3, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 16'h5678, 3, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 16'h0, 0, 1'b0, 1'b0);
        check_eq("full_rdy", {31'd0, bus.in_ready}, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("arst_data", 32'(bus.out_data), 32'd0);
        check_eq("arst_rdy", {31'd0, bus.in_ready}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("arst_hold_rdy", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_eq("arst_rel_rdy", {31'd0, bus.in_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            cycle();
            check_eq("no_stale", {31'd0, bus.out_valid}, 32'd0);
        end
        drive(1'b1, 16'h0082, 1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 16'h0, 0, 1'b0, 1'b0);
        check_eq("post_arst_beat", 32'(bus.out_data), 32'h0000FF82);
        cycle();
        check_eq("final_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
